// File: rtl/gcm_word_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gcm_word_sequencer
// Description : Front-end sequencer for the AES-GCM phase bypasser.
//               Accepts a packet-word stream with a per-packet 96-bit IV,
//               issues two AES counter blocks per accepted word, and
//               produces the bypasser controls (state code / last / ready)
//               delayed by the AES latency so they line up with the
//               keystream. After every eop word the input is stalled for
//               FLUSH_GAP cycles so the bypasser can drain the last word.
// Ports       :
//   clk        in   1    clock
//   rst        in   1    asynchronous active-high reset
//   s_valid    in   1    input word valid
//   s_sop      in   1    first word of packet (qualified by s_valid)
//   s_eop      in   1    last word of packet (qualified by s_valid)
//   s_iv       in   IV_W packet IV, sampled on the sop word
//   s_ready    out  1    word accepted when s_valid && s_ready
//   ctr_valid  out  1    counter blocks valid to AES core
//   ctr_blk0   out  128  {IV,cnt}
//   ctr_blk1   out  128  {IV,cnt+1}
//   o_state    out  4    bypasser state code: 1 FIRST, 2 SECOND, 4 INNER
//   o_last     out  1    last-word flag to bypasser
//   o_ready    out  1    keystream-valid strobe to bypasser
//   o_err      out  1    one-cycle protocol-error pulse
// Revision    : 1.0 - initial release
// ============================================================================
module gcm_word_sequencer #(
    parameter int AES_LAT   = 14,
    parameter int FLUSH_GAP = 3,
    parameter int IV_W      = 96
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    input  logic            s_sop,
    input  logic            s_eop,
    input  logic [IV_W-1:0] s_iv,
    output logic            s_ready,
    output logic            ctr_valid,
    output logic [127:0]    ctr_blk0,
    output logic [127:0]    ctr_blk1,
    output logic [3:0]      o_state,
    output logic            o_last,
    output logic            o_ready,
    output logic            o_err
);

    localparam int         c_CW = 128 - IV_W;
    localparam int         c_GW = (FLUSH_GAP > 1) ? $clog2(FLUSH_GAP) : 1;

    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_W0   = 3'd1;
    localparam logic [2:0] c_S_W1   = 3'd2;
    localparam logic [2:0] c_S_WN   = 3'd3;
    localparam logic [2:0] c_S_GAP  = 3'd4;

    localparam logic [3:0] c_CODE_FIRST  = 4'd1;
    localparam logic [3:0] c_CODE_SECOND = 4'd2;
    localparam logic [3:0] c_CODE_INNER  = 4'd4;

    // FSM
    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;

    // Decoded per-cycle controls
    logic            w_accept;
    logic            w_issue;
    logic            w_err;
    logic [3:0]      w_code;
    logic            w_gap_done;
    logic            w_in_pkt;

    // Datapath
    logic [IV_W-1:0] r_iv;
    logic [c_CW-1:0] r_cnt;
    logic [c_GW-1:0] r_gap_cnt;
    logic            r_ctr_valid;
    logic [127:0]    r_blk0;
    logic [127:0]    r_blk1;
    logic [3:0]      r_code;
    logic            r_last;
    logic            r_err;

    // Alignment delay line: {code[3:0], last, valid}
    logic [5:0]      r_dly [AES_LAT];
    logic [5:0]      w_tap;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                // Non-sop words in IDLE are dropped and leave the FSM here.
                if (w_accept && s_sop) begin
                    w_state_nxt = s_eop ? c_S_GAP : c_S_W0;
                end
            end
            c_S_W0, c_S_W1, c_S_WN: begin
                if (w_accept) begin
                    if (s_eop) begin
                        w_state_nxt = c_S_GAP;
                    end else if (s_sop) begin
                        // Stray sop abandons the current packet and restarts.
                        w_state_nxt = c_S_W0;
                    end else if (r_state == c_S_W0) begin
                        w_state_nxt = c_S_W1;
                    end else begin
                        w_state_nxt = c_S_WN;
                    end
                end
            end
            c_S_GAP: begin
                if (w_gap_done) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output / decode logic
    // ------------------------------------------------------------------------
    always_comb begin
        s_ready    = (r_state != c_S_GAP);
        w_in_pkt   = (r_state == c_S_W0) || (r_state == c_S_W1) ||
                     (r_state == c_S_WN);
        w_accept   = s_valid && s_ready;
        w_gap_done = (r_gap_cnt == c_GW'(FLUSH_GAP - 1));
        // A word produces counter blocks unless it is a non-sop word in IDLE.
        w_issue    = w_accept && (s_sop || w_in_pkt);
        w_err      = w_accept && (s_sop ? w_in_pkt : !w_in_pkt);
        w_code     = c_CODE_INNER;
        if (s_sop) begin
            w_code = c_CODE_FIRST;
        end else if (r_state == c_S_W0) begin
            w_code = c_CODE_SECOND;
        end
    end

    // ------------------------------------------------------------------------
    // Counter-block generation and issue
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iv        <= '0;
            r_cnt       <= c_CW'(1);
            r_ctr_valid <= 1'b0;
            r_blk0      <= '0;
            r_blk1      <= '0;
            r_code      <= c_CODE_FIRST;
            r_last      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_ctr_valid <= w_issue;
            r_err       <= w_err;
            if (w_issue) begin
                r_code <= w_code;
                r_last <= s_eop;
                if (s_sop) begin
                    // J0 (tag block) and the first data counter.
                    r_iv   <= s_iv;
                    r_blk0 <= {s_iv, c_CW'(1)};
                    r_blk1 <= {s_iv, c_CW'(2)};
                    r_cnt  <= c_CW'(3);
                end else begin
                    // Counter arithmetic wraps modulo 2^c_CW by design.
                    r_blk0 <= {r_iv, r_cnt};
                    r_blk1 <= {r_iv, r_cnt + c_CW'(1)};
                    r_cnt  <= r_cnt + c_CW'(2);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Flush-gap counter: counts cycles spent in GAP
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap_cnt <= '0;
        end else if ((r_state == c_S_GAP) && !w_gap_done) begin
            r_gap_cnt <= r_gap_cnt + c_GW'(1);
        end else begin
            r_gap_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Alignment delay line. The entry shifted in alongside ctr_valid reaches
    // the tap exactly AES_LAT cycles later, matching keystream arrival.
    // Empty slots carry valid=0 so the tap decodes to the idle code.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < AES_LAT; i++) begin
                r_dly[i] <= '0;
            end
        end else begin
            r_dly[0] <= {r_code, r_last, r_ctr_valid};
            for (int i = 1; i < AES_LAT; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    assign w_tap = r_dly[AES_LAT-1];

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ctr_valid = r_ctr_valid;
    assign ctr_blk0  = r_blk0;
    assign ctr_blk1  = r_blk1;
    assign o_err     = r_err;
    assign o_ready   = w_tap[0];
    assign o_last    = w_tap[0] & w_tap[1];
    // FIRST is the idle code the bypasser flushes on.
    assign o_state   = w_tap[0] ? w_tap[5:2] : c_CODE_FIRST;

endmodule
`default_nettype wire

// File: tb/tb_gcm_word_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_gcm_word_sequencer
// Description : Self-checking bench for gcm_word_sequencer. A packet-level
//               reference model predicts acceptance, counter blocks, error
//               pulses and the time-stamped bypasser controls.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gcm_word_sequencer;

    localparam int AES_LAT   = 14;
    localparam int FLUSH_GAP = 3;
    localparam int IV_W      = 96;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            s_valid = 1'b0;
    logic            s_sop = 1'b0;
    logic            s_eop = 1'b0;
    logic [IV_W-1:0] s_iv = '0;
    logic            s_ready;
    logic            ctr_valid;
    logic [127:0]    ctr_blk0;
    logic [127:0]    ctr_blk1;
    logic [3:0]      o_state;
    logic            o_last;
    logic            o_ready;
    logic            o_err;

    gcm_word_sequencer #(
        .AES_LAT   (AES_LAT),
        .FLUSH_GAP (FLUSH_GAP),
        .IV_W      (IV_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_sop     (s_sop),
        .s_eop     (s_eop),
        .s_iv      (s_iv),
        .s_ready   (s_ready),
        .ctr_valid (ctr_valid),
        .ctr_blk0  (ctr_blk0),
        .ctr_blk1  (ctr_blk1),
        .o_state   (o_state),
        .o_last    (o_last),
        .o_ready   (o_ready),
        .o_err     (o_err)
    );

    always #5 clk = ~clk;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed control vector: {s_ready, ctr_valid, o_err, o_ready, o_last, o_state}
    logic [8:0] w_obs;
    assign w_obs = {s_ready, ctr_valid, o_err, o_ready, o_last, o_state};

    localparam logic [8:0] c_RESET_CTL = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};

    // ---------------------------------------------------------------- model
    bit              m_busy;
    int              m_pos;
    logic [IV_W-1:0] m_iv;
    logic [31:0]     m_next;
    int              m_gap;
    bit [4:0]        m_tap [int];   // cycle -> {code, last}

    logic [8:0]      e_ctl;
    logic [127:0]    e_blk0;
    logic [127:0]    e_blk1;
    logic            e_cv;

    task automatic model_reset();
        m_busy = 1'b0;
        m_pos  = 0;
        m_next = 32'd1;
        m_gap  = 0;
        m_tap.delete();
    endtask

    // Drive one word slot (at a negedge), predict the state right after the
    // next rising edge, then advance to the following negedge.
    task automatic run_cycle(input bit v, input bit s, input bit e,
                             input logic [IV_W-1:0] iv);
        int         n;
        bit         val;
        bit         err;
        bit         lst;
        logic [3:0] code;
        logic [3:0] st;
        logic       tl;
        logic       tr;
        s_valid = v;
        s_sop   = s;
        s_eop   = e;
        s_iv    = iv;
        n    = cyc + 1;
        val  = 1'b0;
        err  = 1'b0;
        lst  = 1'b0;
        code = 4'd1;
        if (m_gap > 0) begin
            m_gap--;
        end else if (v) begin
            if (s) begin
                err    = m_busy;
                m_iv   = iv;
                e_blk0 = {iv, 32'd1};
                e_blk1 = {iv, 32'd2};
                m_next = 32'd3;
                m_pos  = 1;
                code   = 4'd1;
                val    = 1'b1;
            end else if (!m_busy) begin
                err = 1'b1;
            end else begin
                m_pos++;
                code   = (m_pos == 2) ? 4'd2 : 4'd4;
                e_blk0 = {m_iv, m_next};
                e_blk1 = {m_iv, m_next + 32'd1};
                m_next = m_next + 32'd2;
                val    = 1'b1;
            end
            if (val) begin
                lst    = e;
                m_busy = !e;
                if (e) m_gap = FLUSH_GAP;
                m_tap[n + AES_LAT] = {code, lst};
            end
        end
        if (m_tap.exists(n)) begin
            tr = 1'b1;
            {st, tl} = m_tap[n];
        end else begin
            tr = 1'b0;
            st = 4'd1;
            tl = 1'b0;
        end
        e_cv  = val;
        e_ctl = {(m_gap == 0), val, err, tr, tl, st};
        @(negedge clk);
    endtask

    function automatic logic [IV_W-1:0] rand_iv();
        return {$urandom, $urandom, $urandom};
    endfunction

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (w_obs !== c_RESET_CTL) begin
            errors++;
            $display("FAIL reset ctl got=%b exp=%b", w_obs, c_RESET_CTL);
        end
        checks++;
        if ({ctr_blk0, ctr_blk1} !== 256'd0) begin
            errors++;
            $display("FAIL reset blk got=%h/%h exp=0", ctr_blk0, ctr_blk1);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b0, 1'b0, 1'b0, '0);
            checks++;
            if (w_obs !== e_ctl) begin
                errors++;
                $display("FAIL reset_idle ctl cyc=%0d got=%b exp=%b", cyc, w_obs, e_ctl);
            end
        end
    endtask

    task automatic test_single_word();
        logic [IV_W-1:0] iv;
        iv = {12{8'hA5}};
        for (int i = 0; i < AES_LAT + 6; i++) begin
            run_cycle(i == 0, i == 0, i == 0, iv);
            checks++;
            if (w_obs !== e_ctl) begin
                errors++;
                $display("FAIL single ctl cyc=%0d got=%b exp=%b", cyc, w_obs, e_ctl);
            end
            if (e_cv) begin
                checks++;
                if ({ctr_blk0, ctr_blk1} !== {e_blk0, e_blk1}) begin
                    errors++;
                    $display("FAIL single blk cyc=%0d got=%h/%h exp=%h/%h", cyc, ctr_blk0, ctr_blk1, e_blk0, e_blk1);
                end
            end
        end
    endtask

    task automatic test_four_word();
        logic [IV_W-1:0] iv;
        iv = rand_iv();
        for (int i = 0; i < AES_LAT + 8; i++) begin
            run_cycle(i < 4, i == 0, i == 3, iv);
            checks++;
            if (w_obs !== e_ctl) begin
                errors++;
                $display("FAIL four_word ctl cyc=%0d got=%b exp=%b", cyc, w_obs, e_ctl);
            end
            if (e_cv) begin
                checks++;
                if ({ctr_blk0, ctr_blk1} !== {e_blk0, e_blk1}) begin
                    errors++;
                    $display("FAIL four_word blk cyc=%0d got=%h/%h exp=%h/%h", cyc, ctr_blk0, ctr_blk1, e_blk0, e_blk1);
                end
            end
        end
    endtask

    task automatic test_mid_sop();
        logic [IV_W-1:0] iv_a;
        logic [IV_W-1:0] iv_b;
        iv_a = rand_iv();
        iv_b = rand_iv();
        for (int i = 0; i < AES_LAT + 10; i++) begin
            // words: sop, w, sop(new IV), w, w+eop; with one idle hole
            case (i)
                0:       run_cycle(1'b1, 1'b1, 1'b0, iv_a);
                1:       run_cycle(1'b1, 1'b0, 1'b0, iv_a);
                2:       run_cycle(1'b0, 1'b0, 1'b0, iv_a);
                3:       run_cycle(1'b1, 1'b1, 1'b0, iv_b);
                4:       run_cycle(1'b1, 1'b0, 1'b0, iv_a);
                5:       run_cycle(1'b1, 1'b0, 1'b1, iv_a);
                default: run_cycle(1'b0, 1'b0, 1'b0, '0);
            endcase
            checks++;
            if (w_obs !== e_ctl) begin
                errors++;
                $display("FAIL mid_sop ctl cyc=%0d got=%b exp=%b", cyc, w_obs, e_ctl);
            end
            if (e_cv) begin
                checks++;
                if ({ctr_blk0, ctr_blk1} !== {e_blk0, e_blk1}) begin
                    errors++;
                    $display("FAIL mid_sop blk cyc=%0d got=%h/%h exp=%h/%h", cyc, ctr_blk0, ctr_blk1, e_blk0, e_blk1);
                end
            end
        end
    endtask

    task automatic test_idle_nonsop();
        for (int i = 0; i < AES_LAT + 4; i++) begin
            run_cycle(i < 2, 1'b0, i == 1, rand_iv());
            checks++;
            if (w_obs !== e_ctl) begin
                errors++;
                $display("FAIL idle_nonsop ctl cyc=%0d got=%b exp=%b", cyc, w_obs, e_ctl);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [IV_W-1:0] iv;
        // sop&eop word, then a sop held valid through the flush gap, twice.
        for (int i = 0; i < 2 * FLUSH_GAP + AES_LAT + 8; i++) begin
            iv = rand_iv();
            run_cycle(i < 2 * FLUSH_GAP + 3, 1'b1, 1'b1, iv);
            checks++;
            if (w_obs !== e_ctl) begin
                errors++;
                $display("FAIL back_to_back ctl cyc=%0d got=%b exp=%b", cyc, w_obs, e_ctl);
            end
            if (e_cv) begin
                checks++;
                if ({ctr_blk0, ctr_blk1} !== {e_blk0, e_blk1}) begin
                    errors++;
                    $display("FAIL back_to_back blk cyc=%0d got=%h/%h exp=%h/%h", cyc, ctr_blk0, ctr_blk1, e_blk0, e_blk1);
                end
            end
        end
    endtask

    task automatic test_reset_inflight();
        logic [IV_W-1:0] iv;
        iv = rand_iv();
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b1, i == 0, 1'b0, iv);
            checks++;
            if (w_obs !== e_ctl) begin
                errors++;
                $display("FAIL inflight ctl cyc=%0d got=%b exp=%b", cyc, w_obs, e_ctl);
            end
        end
        s_valid = 1'b0;
        s_sop   = 1'b0;
        s_eop   = 1'b0;
        rst     = 1'b1;
        #1;
        checks++;
        if (w_obs !== c_RESET_CTL) begin
            errors++;
            $display("FAIL inflight_async ctl got=%b exp=%b", w_obs, c_RESET_CTL);
        end
        checks++;
        if ({ctr_blk0, ctr_blk1} !== 256'd0) begin
            errors++;
            $display("FAIL inflight_async blk got=%h/%h exp=0", ctr_blk0, ctr_blk1);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2 * AES_LAT + 2; i++) begin
            run_cycle(1'b0, 1'b0, 1'b0, '0);
            checks++;
            if (w_obs !== e_ctl) begin
                errors++;
                $display("FAIL post_reset ctl cyc=%0d got=%b exp=%b", cyc, w_obs, e_ctl);
            end
        end
    endtask

    task automatic test_random();
        bit v;
        bit s;
        bit e;
        for (int i = 0; i < 1500; i++) begin
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 9) < 2);
            e = ($urandom_range(0, 9) < 2);
            run_cycle(v, s, e, rand_iv());
            checks++;
            if (w_obs !== e_ctl) begin
                errors++;
                $display("FAIL random ctl cyc=%0d got=%b exp=%b", cyc, w_obs, e_ctl);
            end
            if (e_cv) begin
                checks++;
                if ({ctr_blk0, ctr_blk1} !== {e_blk0, e_blk1}) begin
                    errors++;
                    $display("FAIL random blk cyc=%0d got=%h/%h exp=%h/%h", cyc, ctr_blk0, ctr_blk1, e_blk0, e_blk1);
                end
            end
        end
        for (int i = 0; i < AES_LAT + FLUSH_GAP + 2; i++) begin
            run_cycle(1'b0, 1'b0, 1'b0, '0);
            checks++;
            if (w_obs !== e_ctl) begin
                errors++;
                $display("FAIL random_drain ctl cyc=%0d got=%b exp=%b", cyc, w_obs, e_ctl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_four_word();
        test_mid_sop();
        test_idle_nonsop();
        test_back_to_back();
        test_reset_inflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
